// File: rtl/odd_parity_serializer.sv
// odd_parity_serializer
//   Takes a DATA_W-bit word over a valid/ready handshake and sends it LSB
//   first on a single wire as a framed character:
//     start(0) | data[0] .. data[DATA_W-1] | odd parity | stop(1)
//   Each bit is held on ser_out for CLKS_PER_BIT clocks. The parity bit is
//   built one bit at a time while the data shifts out.
//
// Handshake: a word transfers on any rising edge where in_valid && in_ready.
//   in_ready is high only in IDLE. The source may raise or drop in_valid at
//   any time. in_data is sampled only on the transfer edge.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any frame in flight
//   in_data    word to transmit
//   in_valid   source has a word
//   in_ready   block can accept (state == IDLE)
//   ser_out    registered serial line, idle high
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the first IDLE cycle after STOP
//   parity_bit parity of the last frame; updated on entry to PARITY
//
// The FSM state is held in 'state' (type state_t) so checkers can bind to it.
module odd_parity_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              done,
  output logic              parity_bit
);

  // Both counters are at least 1 bit wide, including the degenerate
  // CLKS_PER_BIT=1 and DATA_W=1 cases.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              par_q, par_n;
  logic [BIT_W-1:0]  bit_q, bit_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              ser_q, ser_n;
  logic              done_q, done_n;
  logic              pbit_q, pbit_n;
  logic              last_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
      pbit_q  <= 1'b0;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      bit_q   <= bit_n;
      cnt_q   <= cnt_n;
      ser_q   <= ser_n;
      done_q  <= done_n;
      pbit_q  <= pbit_n;
    end
  end

  always_comb begin
    state_n  = state;
    shift_n  = shift_q;
    par_n    = par_q;
    bit_n    = bit_q;
    cnt_n    = cnt_q;
    done_n   = 1'b0;
    pbit_n   = pbit_q;
    ser_n    = 1'b1;
    last_clk = (cnt_q == CNT_LAST);

    case (state)
      IDLE: begin
        if (in_valid) begin
          // Parity starts at 1, so XOR-ing in every data bit gives odd parity.
          shift_n = in_data;
          par_n   = 1'b1;
          bit_n   = '0;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (last_clk) begin
          cnt_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (last_clk) begin
          cnt_n   = '0;
          par_n   = par_q ^ shift_q[0];
          shift_n = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_n   = '0;
            pbit_n  = par_q ^ shift_q[0];
            state_n = PARITY;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (last_clk) begin
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (last_clk) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // ser_out is registered. Its value is taken from the state being
    // entered, so the start bit is on the line in the first cycle after the
    // transfer.
    case (state_n)
      START:   ser_n = 1'b0;
      DATA:    ser_n = shift_n[0];
      PARITY:  ser_n = par_n;
      default: ser_n = 1'b1;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign ser_out    = ser_q;
  assign done       = done_q;
  assign parity_bit = pbit_q;

endmodule

// File: tb/tb_odd_parity_serializer.sv
// Bench for odd_parity_serializer. Two instances share one clock:
//   u0: DATA_W=8, CLKS_PER_BIT=4
//   u1: DATA_W=1, CLKS_PER_BIT=1
// The drivers push {word, accept cycle} into a per-instance queue. A monitor
// samples each line at the falling edge. On each done pulse it pops one
// entry, rebuilds the expected framed bit stream from the word, and compares
// that stream, the parity output and the start and done latencies.
module tb_odd_parity_serializer;
  localparam int W0 = 8, C0 = 4, W1 = 1, C1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n      [2];
  logic        in_valid   [2];
  logic [31:0] din        [2];
  logic        in_ready   [2];
  logic        ser_out    [2];
  logic        busy       [2];
  logic        done       [2];
  logic        parity_bit [2];

  odd_parity_serializer #(.DATA_W(W0), .CLKS_PER_BIT(C0)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .in_data(din[0][7:0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .busy(busy[0]),
    .done(done[0]), .parity_bit(parity_bit[0])
  );

  odd_parity_serializer #(.DATA_W(W1), .CLKS_PER_BIT(C1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .in_data(din[1][0:0]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .busy(busy[1]),
    .done(done[1]), .parity_bit(parity_bit[1])
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] acc;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int total = 0;
  int bad   = 0;

  logic [63:0] cap           [2];
  int          ncap          [2];
  logic        prev_busy     [2];
  int unsigned start_cyc     [2];
  int unsigned last_done_cyc [2];

  function automatic int wof(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic int cof(input int k);
    return (k == 0) ? C0 : C1;
  endfunction

  function automatic logic [31:0] mask(input int k);
    return (k == 0) ? 32'h0000_00FF : 32'h0000_0001;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t qpop(input int k);
    exp_t e;
    if (k == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    return e;
  endfunction

  function automatic void qpush(input int k, input exp_t e);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor step for one instance, run at every falling edge.
  task automatic mon_step(input int k);
    exp_t        e;
    int          w, c, n;
    logic [63:0] ev;
    logic        pexp, bitv;
    w = wof(k);
    c = cof(k);
    n = (w + 3) * c;
    chk($sformatf("ready_vs_busy%0d", k), 64'(in_ready[k]), 64'(!busy[k]));
    if (done[k]) begin
      if (qsize(k) == 0) begin
        chk($sformatf("unexpected_done%0d", k), 64'd1, 64'd0);
      end else begin
        e    = qpop(k);
        pexp = (($countones(e.data) % 2) == 0);
        ev   = '0;
        for (int b = 0; b < w + 3; b++) begin
          if (b == 0)          bitv = 1'b0;
          else if (b <= w)     bitv = e.data[b-1];
          else if (b == w + 1) bitv = pexp;
          else                 bitv = 1'b1;
          for (int j = 0; j < c; j++) ev[b*c+j] = bitv;
        end
        chk($sformatf("frame_len%0d", k), 64'(ncap[k]), 64'(n));
        chk($sformatf("frame_bits%0d", k), cap[k], ev);
        chk($sformatf("parity_bit%0d", k), 64'(parity_bit[k]), 64'(pexp));
        chk($sformatf("start_latency%0d", k), 64'(start_cyc[k]), 64'(e.acc + 1));
        chk($sformatf("done_latency%0d", k), 64'(cyc), 64'(e.acc + 32'(n) + 1));
      end
      last_done_cyc[k] = cyc;
    end
    if (busy[k]) begin
      if (!prev_busy[k]) begin
        start_cyc[k] = cyc;
        ncap[k]      = 0;
        cap[k]       = '0;
      end
      if (ncap[k] < 64) cap[k][ncap[k]] = ser_out[k];
      ncap[k]++;
    end else begin
      chk($sformatf("idle_line_high%0d", k), 64'(ser_out[k]), 64'd1);
    end
    prev_busy[k] = busy[k];
  endtask

  always @(negedge clk) mon_step(0);
  always @(negedge clk) mon_step(1);

  // Presents one word and waits, with a bounded wait, for it to be accepted.
  // The entry is pushed at the falling edge that precedes the accepting edge.
  // With keep=1, in_valid stays high after the transfer.
  task automatic send(input int k, input logic [31:0] d, input bit keep, output logic [31:0] acc);
    int   g;
    exp_t e;
    g = 0;
    acc = '0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    din[k]      = d;
    while (!in_ready[k] && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) begin
      chk($sformatf("accept_timeout%0d", k), 64'd0, 64'd1);
      in_valid[k] = 1'b0;
    end else begin
      e.data = d & mask(k);
      e.acc  = cyc;
      acc    = cyc;
      qpush(k, e);
      @(posedge clk);
      #1;
      din[k] = $urandom;
      if (!keep) in_valid[k] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while ((qsize(k) != 0 || busy[k]) && g < 3000);
    if (g >= 3000) chk($sformatf("idle_timeout%0d", k), 64'd0, 64'd1);
  endtask

  task automatic random_run(input int k, input int count);
    logic [31:0] acc;
    bit          keep;
    for (int i = 0; i < count; i++) begin
      keep = (i != count - 1) && ($urandom_range(0, 3) == 0);
      send(k, $urandom, keep, acc);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] acc, acc2;
    int          g;
    for (int k = 0; k < 2; k++) begin
      rst_n[k]         = 1'b0;
      in_valid[k]      = 1'b1;
      din[k]           = $urandom;
      cap[k]           = '0;
      ncap[k]          = 0;
      prev_busy[k]     = 1'b0;
      start_cyc[k]     = 0;
      last_done_cyc[k] = 0;
    end

    // Reset state, with in_valid high while reset is held.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ser_out%0d", k), 64'(ser_out[k]), 64'd1);
      chk($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
      chk($sformatf("rst_done%0d", k), 64'(done[k]), 64'd0);
      chk($sformatf("rst_parity%0d", k), 64'(parity_bit[k]), 64'd0);
      chk($sformatf("rst_in_ready%0d", k), 64'(in_ready[k]), 64'd1);
      in_valid[k] = 1'b0;
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Directed words with known parity.
    send(0, 32'hA5, 0, acc); wait_idle(0); chk("a5_parity", 64'(parity_bit[0]), 64'd1);
    send(0, 32'h07, 0, acc); wait_idle(0); chk("07_parity", 64'(parity_bit[0]), 64'd0);
    send(0, 32'h00, 0, acc); wait_idle(0); chk("00_parity", 64'(parity_bit[0]), 64'd1);
    send(0, 32'hFF, 0, acc); wait_idle(0); chk("ff_parity", 64'(parity_bit[0]), 64'd1);

    // Back-to-back transfer with in_valid held high.
    send(0, 32'h01, 1, acc);
    send(0, 32'h03, 0, acc2);
    @(negedge clk);
    #1;
    chk("b2b_accept_in_done", 64'(acc2), 64'(last_done_cyc[0]));
    chk("b2b_gap", 64'(start_cyc[0] - last_done_cyc[0]), 64'd1);
    chk("b2b_par_first", 64'(parity_bit[0]), 64'd0);
    wait_idle(0);
    chk("b2b_par_second", 64'(parity_bit[0]), 64'd1);

    // Reset asserted during the third data bit; 8'hF0 has data[2]=0 there.
    send(0, 32'hF0, 0, acc);
    while (cyc < acc + 13) @(negedge clk);
    #1;
    chk("pre_rst_line", 64'(ser_out[0]), 64'd0);
    rst_n[0] = 1'b0;
    #1;
    chk("mid_rst_ser_out", 64'(ser_out[0]), 64'd1);
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("mid_rst_parity", 64'(parity_bit[0]), 64'd0);
    exp_q0.delete();
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    send(0, 32'h5A, 0, acc); wait_idle(0); chk("5a_parity", 64'(parity_bit[0]), 64'd1);

    // in_valid pulses while busy must not be accepted.
    send(0, 32'h3C, 0, acc);
    g = 0;
    while (g < 200) begin
      @(negedge clk);
      #1;
      if (!busy[0]) break;
      if ($urandom_range(0, 1) == 1) begin
        in_valid[0] = 1'b1;
        din[0]      = $urandom;
        chk("ready_low_while_busy", 64'(in_ready[0]), 64'd0);
        @(negedge clk);
        in_valid[0] = 1'b0;
      end
      g++;
    end
    wait_idle(0);

    random_run(0, 20);

    // DATA_W=1, CLKS_PER_BIT=1 instance.
    send(1, 32'h1, 0, acc); wait_idle(1); chk("w1_one_parity", 64'(parity_bit[1]), 64'd0);
    send(1, 32'h0, 0, acc); wait_idle(1); chk("w1_zero_parity", 64'(parity_bit[1]), 64'd1);
    send(1, 32'h1, 1, acc);
    send(1, 32'h1, 0, acc2);
    @(negedge clk);
    #1;
    chk("w1_b2b_gap", 64'(start_cyc[1] - last_done_cyc[1]), 64'd1);
    wait_idle(1);
    random_run(1, 30);

    repeat (4) @(negedge clk);
    chk("q0_drained", 64'(qsize(0)), 64'd0);
    chk("q1_drained", 64'(qsize(1)), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odd_parity_serializer.md
Name: odd_parity_serializer

Overview:
- Sequencer for the odd-parity datapath.
- Accepts a parallel DATA_W-bit word over a valid/ready handshake and shifts it out serially, LSB first, as a framed character: start bit, data bits, odd-parity bit, stop bit.
- Parity is accumulated bit-serially while the data shifts out.
- Sits between a word-producing source and a single-wire serial link.

Parameters:
- DATA_W, 8, data word width in bits; legal range 1..32.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on ser_out; legal range 1..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  word to transmit; sampled only on an accept cycle.
- in_valid  input  1  source has a word.
- in_ready  output  1  block can accept; equals (state==IDLE).
- ser_out  output  1  serial line; idle-high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a frame completes.
- parity_bit  output  1  parity bit of the most recently transmitted frame; held until the next frame's PARITY state.

Behaviour:
- Reset, asynchronous, active-low:
  - State goes to IDLE.
  - ser_out=1, busy=0, done=0, parity_bit=0; shift, bit and clock counters cleared.
  - in_ready reads 1, but no transfer is captured while rst_n=0.
  - Reset mid-frame aborts the frame immediately. ser_out returns high with no stop bit, and no done pulse is issued.
- Accept: in_valid & in_ready at a rising edge. in_data is latched into the shift register, the running parity register is set to 1, and the FSM moves to START. in_data changes after accept are ignored.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- Each non-IDLE state holds for CLKS_PER_BIT cycles, counted by a clock counter that reloads on every state or bit change.
- START: ser_out=0.
- DATA: ser_out = shift[0]. On the last cycle of each bit period:
  - parity ^= shift[0];
  - shift >>= 1;
  - bit counter increments.
  - After DATA_W bits, go to PARITY.
- PARITY: ser_out = running parity, which equals ~^data. parity_bit is updated on entry to PARITY. The count of ones in data plus the parity bit is always odd.
- STOP: ser_out=1. On the last STOP cycle, the next state is IDLE.
- done: registered pulse, high for exactly the first IDLE cycle after STOP. in_ready=1 in that same cycle, so a back-to-back accept is allowed there.
- Latency:
  - The start bit appears on ser_out in the cycle after accept. ser_out is registered and driven from state.
  - Frame length is (DATA_W+3)*CLKS_PER_BIT cycles.
  - The minimum inter-frame gap is 1 idle-high cycle.
- CLKS_PER_BIT=1: one cycle per bit. All rules still hold, and the counter is never zero-width (minimum 1 bit).
- in_valid held high across a frame: no second accept until IDLE. Words are never dropped or duplicated.
- in_valid deasserted before accept: no transfer, and no obligation on the source.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, in_data=8'hA5 accepted at cycle T:
  - ser_out from T+1, each bit held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1 | 1.
  - parity_bit=1; done pulses at T+45; busy high T+1..T+44.
- in_data=8'h07 -> parity bit 0 on the line, parity_bit=0. in_data=8'h00 -> parity bit 1. in_data=8'hFF -> parity bit 1.
- Back-to-back, in_valid held high with 8'h01 then 8'h03:
  - the second accept occurs in the done cycle;
  - exactly 1 idle-high cycle separates the stop bit from the next start bit;
  - parity bits are 0 then 1.
- Reset mid-DATA: assert rst_n=0 at the 3rd data bit. ser_out=1 and busy=0 immediately (same cycle, asynchronous); no done pulse. After release, a new 8'h5A frame is correct with parity bit 1.
- CLKS_PER_BIT=1, DATA_W=1: in_data=1 -> ser_out 0,1,0,1 over 4 cycles, done pulse on the 5th cycle. in_data=0 -> parity bit 1.
- Handshake: pulse in_valid while busy. No accept and in_ready=0 throughout; the frame is unaffected.
